// File: rtl/wb_write_arbiter.sv
// Writeback arbiter for the regfile's single write port. Each functional-unit
// channel has its own small FIFO; one head is granted per cycle round-robin.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

module wb_write_arbiter #(
  parameter int NUM_FU    = 3,
  parameter int PHY_REG_W = `PHYSICAL_REG_NUM_WIDTH,
  parameter int REG_VAL_W = `REG_VAL_WIDTH,
  parameter int BUF_DEPTH = 2,
  localparam int PEND_W   = $clog2(NUM_FU*BUF_DEPTH+1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_FU-1:0]             fu_valid,
  output logic [NUM_FU-1:0]             fu_ready,
  input  logic [NUM_FU*PHY_REG_W-1:0]   fu_phy_reg,
  input  logic [NUM_FU*REG_VAL_W-1:0]   fu_val,
  output logic                          wb_wr_en,
  output logic [PHY_REG_W-1:0]          wb_phy_reg,
  output logic [REG_VAL_W-1:0]          wb_val,
  output logic [NUM_FU-1:0]             wb_grant,
  output logic [PEND_W-1:0]             pending_cnt
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH+1);
  localparam int FU_W  = $clog2(NUM_FU);

  logic [PHY_REG_W-1:0] tag_mem_q [NUM_FU][BUF_DEPTH];
  logic [REG_VAL_W-1:0] val_mem_q [NUM_FU][BUF_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q  [NUM_FU];
  logic [PTR_W-1:0]     rd_ptr_q  [NUM_FU];
  logic [CNT_W-1:0]     cnt_q     [NUM_FU];
  logic [CNT_W-1:0]     cnt_d     [NUM_FU];

  logic [FU_W-1:0]      rr_ptr_q, rr_ptr_d, winner, search_idx;
  logic [FU_W:0]        search_sum;
  logic                 found;
  logic [NUM_FU-1:0]    push, pop, nonempty;

  logic                 wb_wr_en_q;
  logic [PHY_REG_W-1:0] wb_phy_reg_q;
  logic [REG_VAL_W-1:0] wb_val_q;
  logic [NUM_FU-1:0]    wb_grant_q;
  logic [PEND_W-1:0]    pending_sum;

  // Ready depends only on registered counts, so a full channel stays blocked
  // at the edge where it is also popped.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    fu_ready    = '0;
    nonempty    = '0;
    push        = '0;
    pending_sum = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = (cnt_q[i] < CNT_W'(BUF_DEPTH));
      nonempty[i] = (cnt_q[i] != '0);
      push[i]     = fu_valid[i] & fu_ready[i] & ~flush;
      pending_sum = pending_sum + PEND_W'(cnt_q[i]);
    end
  end

  // Rotating priority search from rr_ptr_q over channels non-empty at cycle start.
  always_comb begin
    found      = 1'b0;
    winner     = '0;
    search_sum = '0;
    search_idx = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      search_sum = {1'b0, rr_ptr_q} + (FU_W+1)'(k);
      if (search_sum >= (FU_W+1)'(NUM_FU)) search_sum = search_sum - (FU_W+1)'(NUM_FU);
      search_idx = search_sum[FU_W-1:0];
      if (!found && nonempty[search_idx]) begin
        found  = 1'b1;
        winner = search_idx;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (found && !flush) pop[winner] = 1'b1;
    rr_ptr_d = (winner == FU_W'(NUM_FU-1)) ? '0 : winner + FU_W'(1);
    for (int i = 0; i < NUM_FU; i++) begin
      cnt_d[i] = cnt_q[i];
      if (push[i] && !pop[i])      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (!push[i] && pop[i]) cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
  end

  // NOTE: FIFO payload is not reset; pointers and counts alone decide validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        tag_mem_q[i][wr_ptr_q[i]] <= fu_phy_reg[i*PHY_REG_W +: PHY_REG_W];
        val_mem_q[i][wr_ptr_q[i]] <= fu_val[i*REG_VAL_W +: REG_VAL_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_ptr_q     <= '0;
      wb_wr_en_q   <= 1'b0;
      wb_phy_reg_q <= '0;
      wb_val_q     <= '0;
      wb_grant_q   <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_ptr_q   <= '0;
      wb_wr_en_q <= 1'b0;
      wb_grant_q <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
        cnt_q[i] <= cnt_d[i];
      end
      wb_wr_en_q <= found;
      wb_grant_q <= found ? (NUM_FU'(1) << winner) : '0;
      if (found) begin
        rr_ptr_q     <= rr_ptr_d;
        wb_phy_reg_q <= tag_mem_q[winner][rd_ptr_q[winner]];
        wb_val_q     <= val_mem_q[winner][rd_ptr_q[winner]];
      end
    end
  end

  assign wb_wr_en    = wb_wr_en_q;
  assign wb_phy_reg  = wb_phy_reg_q;
  assign wb_val      = wb_val_q;
  assign wb_grant    = wb_grant_q;
  assign pending_cnt = pending_sum;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: three channels, depth-2 FIFOs, 6-bit tags.
module tb_wb_write_arbiter;

  localparam int NF = 3;
  localparam int TW = 6;
  localparam int VW = 32;
  localparam int BD = 2;
  localparam int PW = $clog2(NF*BD+1);

  logic            clk, reset, flush;
  logic [NF-1:0]   fu_valid, fu_ready, wb_grant;
  logic [NF*TW-1:0] fu_phy_reg;
  logic [NF*VW-1:0] fu_val;
  logic            wb_wr_en;
  logic [TW-1:0]   wb_phy_reg;
  logic [VW-1:0]   wb_val;
  logic [PW-1:0]   pending_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  wb_write_arbiter #(.NUM_FU(NF), .PHY_REG_W(TW), .REG_VAL_W(VW), .BUF_DEPTH(BD)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_phy_reg(fu_phy_reg), .fu_val(fu_val),
    .wb_wr_en(wb_wr_en), .wb_phy_reg(wb_phy_reg), .wb_val(wb_val),
    .wb_grant(wb_grant), .pending_cnt(pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] val_of(input logic [TW-1:0] tag);
    return 32'hC0DE_0000 | {26'd0, tag};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int ch, input logic [TW-1:0] tag, input logic [VW-1:0] val);
    fu_valid[ch] = 1'b1;
    fu_phy_reg[ch*TW +: TW] = tag;
    fu_val[ch*VW +: VW] = val;
  endtask

  task automatic idle(input int ch);
    fu_valid[ch] = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    flush = 1'b0;
    fu_valid = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Protocol monitors: grant/enable consistency, occupancy bound, no growth beyond accepted offers.
  int  prev_max;
  bit  prev_ok = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      tests_run++;
      if (wb_wr_en ? !$onehot(wb_grant) : (wb_grant !== '0)) begin
        tests_failed++;
        $display("FAIL grant_onehot: wr_en=%b grant=%b", wb_wr_en, wb_grant);
      end
      tests_run++;
      if (int'(pending_cnt) > NF*BD) begin
        tests_failed++;
        $display("FAIL pending_bound: pending=%0d limit=%0d", pending_cnt, NF*BD);
      end
      if (prev_ok) begin
        tests_run++;
        if (int'(pending_cnt) > prev_max) begin
          tests_failed++;
          $display("FAIL enq_when_not_ready: pending=%0d allowed at most %0d", pending_cnt, prev_max);
        end
      end
      prev_max = int'(pending_cnt) + $countones(fu_valid & fu_ready);
      prev_ok  = 1'b1;
    end else begin
      prev_ok = 1'b0;
    end
  end

  task automatic test_reset();
    #1;
    tests_run++;
    if (wb_wr_en !== 1'b0 || wb_phy_reg !== '0 || wb_val !== '0 || wb_grant !== '0 || pending_cnt !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: en=%b tag=%0d val=%h grant=%b pend=%0d, expected all zero",
               wb_wr_en, wb_phy_reg, wb_val, wb_grant, pending_cnt);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    tests_run++;
    if (fu_ready !== 3'b111) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b expected 111", fu_ready);
    end
  endtask

  task automatic test_single();
    apply_reset();
    offer(1, 6'd5, 32'hDEADBEEF);
    step();
    idle(1);
    tests_run++;
    if (wb_wr_en !== 1'b0 || pending_cnt !== 3'd1) begin
      tests_failed++;
      $display("FAIL single_accept: en=%b pend=%0d, expected en=0 pend=1", wb_wr_en, pending_cnt);
    end
    step();
    tests_run++;
    if (wb_wr_en !== 1'b1 || wb_phy_reg !== 6'd5 || wb_val !== 32'hDEADBEEF || wb_grant !== 3'b010) begin
      tests_failed++;
      $display("FAIL single_write: en=%b tag=%0d val=%h grant=%b, expected en=1 tag=5 val=deadbeef grant=010",
               wb_wr_en, wb_phy_reg, wb_val, wb_grant);
    end
    step();
    tests_run++;
    if (wb_wr_en !== 1'b0 || pending_cnt !== 3'd0 || wb_grant !== 3'b000) begin
      tests_failed++;
      $display("FAIL single_idle: en=%b pend=%0d grant=%b, expected 0/0/000", wb_wr_en, pending_cnt, wb_grant);
    end
  endtask

  task automatic test_round_robin();
    logic [TW-1:0] et [6] = '{6'd10, 6'd20, 6'd30, 6'd11, 6'd21, 6'd31};
    logic [NF-1:0] eg [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [NF-1:0] er [6] = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b111, 3'b111};
    int            ep [6] = '{5, 4, 3, 2, 1, 0};
    apply_reset();
    offer(0, 6'd10, val_of(6'd10)); offer(1, 6'd20, val_of(6'd20)); offer(2, 6'd30, val_of(6'd30));
    step();
    offer(0, 6'd11, val_of(6'd11)); offer(1, 6'd21, val_of(6'd21)); offer(2, 6'd31, val_of(6'd31));
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 0) fu_valid = '0;
      tests_run++;
      if (wb_wr_en !== 1'b1 || wb_phy_reg !== et[k] || wb_val !== val_of(et[k]) || wb_grant !== eg[k] ||
          int'(pending_cnt) != ep[k] || fu_ready !== er[k]) begin
        tests_failed++;
        $display("FAIL rr_order[%0d]: got en=%b tag=%0d val=%h grant=%b pend=%0d rdy=%b, expected en=1 tag=%0d val=%h grant=%b pend=%0d rdy=%b",
                 k, wb_wr_en, wb_phy_reg, wb_val, wb_grant, pending_cnt, fu_ready,
                 et[k], val_of(et[k]), eg[k], ep[k], er[k]);
      end
    end
    step();
    tests_run++;
    if (wb_wr_en !== 1'b0 || pending_cnt !== 3'd0) begin
      tests_failed++;
      $display("FAIL rr_drain: en=%b pend=%0d, expected 0/0", wb_wr_en, pending_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] et [7] = '{6'd50, 6'd60, 6'd40, 6'd51, 6'd61, 6'd41, 6'd42};
    logic [NF-1:0] eg [7] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b001};
    logic [NF-1:0] er [7] = '{3'b011, 3'b110, 3'b111, 3'b110, 3'b110, 3'b111, 3'b111};
    int            ep [7] = '{4, 4, 3, 3, 2, 1, 0};
    apply_reset();
    offer(1, 6'd50, val_of(6'd50)); offer(2, 6'd60, val_of(6'd60));
    step();
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: begin offer(0, 6'd40, val_of(6'd40)); offer(1, 6'd51, val_of(6'd51)); offer(2, 6'd61, val_of(6'd61)); end
        1: begin idle(1); idle(2); offer(0, 6'd41, val_of(6'd41)); end
        2: offer(0, 6'd42, val_of(6'd42));
        4: idle(0);
        default: ;
      endcase
      step();
      tests_run++;
      if (wb_wr_en !== 1'b1 || wb_phy_reg !== et[k] || wb_val !== val_of(et[k]) || wb_grant !== eg[k] ||
          int'(pending_cnt) != ep[k] || fu_ready !== er[k]) begin
        tests_failed++;
        $display("FAIL backpressure[%0d]: got en=%b tag=%0d grant=%b pend=%0d rdy=%b, expected en=1 tag=%0d grant=%b pend=%0d rdy=%b",
                 k, wb_wr_en, wb_phy_reg, wb_grant, pending_cnt, fu_ready, et[k], eg[k], ep[k], er[k]);
      end
    end
    step();
    tests_run++;
    if (wb_wr_en !== 1'b0 || pending_cnt !== 3'd0) begin
      tests_failed++;
      $display("FAIL backpressure_drain: en=%b pend=%0d, expected 0/0", wb_wr_en, pending_cnt);
    end
  endtask

  task automatic test_full_pop();
    logic [TW-1:0] et [5] = '{6'd80, 6'd70, 6'd81, 6'd71, 6'd72};
    logic [NF-1:0] eg [5] = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b100};
    logic [NF-1:0] er [5] = '{3'b011, 3'b111, 3'b011, 3'b111, 3'b111};
    int            ep [5] = '{3, 2, 2, 1, 0};
    apply_reset();
    offer(0, 6'd80, val_of(6'd80)); offer(2, 6'd70, val_of(6'd70));
    step();
    tests_run++;
    if (wb_wr_en !== 1'b0 || pending_cnt !== 3'd2) begin
      tests_failed++;
      $display("FAIL full_pop_load: en=%b pend=%0d, expected en=0 pend=2", wb_wr_en, pending_cnt);
    end
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin offer(0, 6'd81, val_of(6'd81)); offer(2, 6'd71, val_of(6'd71)); end
        1: begin idle(0); offer(2, 6'd72, val_of(6'd72)); end
        3: idle(2);
        default: ;
      endcase
      step();
      tests_run++;
      if (wb_wr_en !== 1'b1 || wb_phy_reg !== et[k] || wb_val !== val_of(et[k]) || wb_grant !== eg[k] ||
          int'(pending_cnt) != ep[k] || fu_ready !== er[k]) begin
        tests_failed++;
        $display("FAIL full_pop[%0d]: got en=%b tag=%0d grant=%b pend=%0d rdy=%b, expected en=1 tag=%0d grant=%b pend=%0d rdy=%b",
                 k, wb_wr_en, wb_phy_reg, wb_grant, pending_cnt, fu_ready, et[k], eg[k], ep[k], er[k]);
      end
    end
    step();
    tests_run++;
    if (wb_wr_en !== 1'b0 || pending_cnt !== 3'd0) begin
      tests_failed++;
      $display("FAIL full_pop_drain: en=%b pend=%0d, expected 0/0", wb_wr_en, pending_cnt);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    offer(0, 6'd1, val_of(6'd1)); offer(1, 6'd2, val_of(6'd2)); offer(2, 6'd3, val_of(6'd3));
    step();
    offer(0, 6'd4, val_of(6'd4)); offer(1, 6'd5, val_of(6'd5)); offer(2, 6'd6, val_of(6'd6));
    step();
    tests_run++;
    if (wb_wr_en !== 1'b1 || wb_phy_reg !== 6'd1 || pending_cnt !== 3'd5) begin
      tests_failed++;
      $display("FAIL flush_preload: en=%b tag=%0d pend=%0d, expected en=1 tag=1 pend=5", wb_wr_en, wb_phy_reg, pending_cnt);
    end
    idle(1); idle(2); offer(0, 6'd7, val_of(6'd7));
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle(0);
    tests_run++;
    if (wb_wr_en !== 1'b0 || wb_grant !== 3'b000 || pending_cnt !== 3'd0 || fu_ready !== 3'b111) begin
      tests_failed++;
      $display("FAIL flush_clear: en=%b grant=%b pend=%0d rdy=%b, expected 0/000/0/111", wb_wr_en, wb_grant, pending_cnt, fu_ready);
    end
    step();
    tests_run++;
    if (wb_wr_en !== 1'b0 || pending_cnt !== 3'd0) begin
      tests_failed++;
      $display("FAIL flush_dropped_offer: en=%b pend=%0d, expected 0/0", wb_wr_en, pending_cnt);
    end
    offer(0, 6'd8, val_of(6'd8)); offer(2, 6'd9, val_of(6'd9));
    step();
    fu_valid = '0;
    step();
    tests_run++;
    if (wb_wr_en !== 1'b1 || wb_phy_reg !== 6'd8 || wb_grant !== 3'b001) begin
      tests_failed++;
      $display("FAIL flush_rr_reset: en=%b tag=%0d grant=%b, expected en=1 tag=8 grant=001", wb_wr_en, wb_phy_reg, wb_grant);
    end
    step();
    tests_run++;
    if (wb_wr_en !== 1'b1 || wb_phy_reg !== 6'd9 || wb_grant !== 3'b100) begin
      tests_failed++;
      $display("FAIL flush_second: en=%b tag=%0d grant=%b, expected en=1 tag=9 grant=100", wb_wr_en, wb_phy_reg, wb_grant);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    offer(0, 6'd30, val_of(6'd30)); offer(1, 6'd31, val_of(6'd31));
    step();
    fu_valid = '0;
    step();
    tests_run++;
    if (wb_wr_en !== 1'b1 || wb_phy_reg !== 6'd30 || pending_cnt !== 3'd1) begin
      tests_failed++;
      $display("FAIL areset_pre: en=%b tag=%0d pend=%0d, expected en=1 tag=30 pend=1", wb_wr_en, wb_phy_reg, pending_cnt);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (wb_wr_en !== 1'b0 || pending_cnt !== 3'd0 || wb_grant !== 3'b000 || wb_phy_reg !== 6'd0) begin
      tests_failed++;
      $display("FAIL areset_immediate: en=%b pend=%0d grant=%b tag=%0d, expected all zero", wb_wr_en, pending_cnt, wb_grant, wb_phy_reg);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (fu_ready !== 3'b111) begin
      tests_failed++;
      $display("FAIL areset_ready: got %b expected 111", fu_ready);
    end
    step();
    tests_run++;
    if (wb_wr_en !== 1'b0 || pending_cnt !== 3'd0) begin
      tests_failed++;
      $display("FAIL areset_lost: en=%b pend=%0d, expected 0/0", wb_wr_en, pending_cnt);
    end
  endtask

  initial begin
    reset      = 1'b1;
    flush      = 1'b0;
    fu_valid   = '0;
    fu_phy_reg = '0;
    fu_val     = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_full_pop();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writeback stage sitting directly upstream of the physical register file's single write port.
- Collects results from NUM_FU functional-unit channels over valid/ready handshakes and buffers each channel in a small FIFO.
- Grants one result per cycle round-robin and drives registered wb_wr_en / wb_phy_reg / wb_val straight into the regfile's dst_wr_en / dst_phy_reg / dst_val.
- Also broadcasts the written tag for wakeup logic.

Parameters:
- NUM_FU, 3, number of functional-unit result channels (2..8).
- PHY_REG_W, `PHYSICAL_REG_NUM_WIDTH, physical register tag width.
- REG_VAL_W, `REG_VAL_WIDTH, result value width.
- BUF_DEPTH, 2, entries per channel FIFO (power of 2, >= 2).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; discards all buffered results.
- fu_valid  input  NUM_FU  bit i: channel i offers a result.
- fu_ready  output  NUM_FU  bit i: channel i FIFO can accept.
- fu_phy_reg  input  NUM_FU*PHY_REG_W  channel i tag at slice [i*PHY_REG_W +: PHY_REG_W].
- fu_val  input  NUM_FU*REG_VAL_W  channel i value at slice [i*REG_VAL_W +: REG_VAL_W].
- wb_wr_en  output  1  registered write enable to the regfile.
- wb_phy_reg  output  PHY_REG_W  registered destination tag.
- wb_val  output  REG_VAL_W  registered destination value.
- wb_grant  output  NUM_FU  registered one-hot of the channel that produced the current write; zero when wb_wr_en=0.
- pending_cnt  output  $clog2(NUM_FU*BUF_DEPTH+1)  total entries buffered across all FIFOs.

Behaviour:
- Reset (async):
  - All FIFOs empty, pointers 0, round-robin pointer rr_ptr=0.
  - wb_wr_en=0, wb_phy_reg=0, wb_val=0, wb_grant=0, pending_cnt=0.
  - fu_ready = all ones as soon as reset deasserts.
- Handshake:
  - Channel i enqueues at a rising edge when fu_valid[i] && fu_ready[i].
  - fu_ready[i] = (count_i < BUF_DEPTH); it is combinational from registered count only and never depends on fu_valid.
  - A producer must hold fu_valid/tag/value stable until accepted.
- Arbitration (each edge, flush=0):
  - Candidate set = channels whose FIFO is non-empty at the start of the cycle. Same-cycle enqueues are not candidates.
  - Search starts at rr_ptr and wraps modulo NUM_FU; the first candidate wins.
  - The winner's head is popped. Outputs update to wb_wr_en=1, wb_phy_reg/wb_val = head, wb_grant = one-hot(winner).
  - rr_ptr <= (winner+1) mod NUM_FU.
  - No candidate: wb_wr_en<=0, wb_grant<=0. wb_phy_reg/wb_val hold their previous values; rr_ptr holds.
- Latency:
  - A result accepted at edge N into an empty FIFO with no competitors appears on wb_* after edge N+1.
  - The regfile writes it at edge N+2.
  - Sustained throughput: 1 write per cycle whenever pending_cnt > 0.
- Simultaneous events:
  - Enqueue and pop on the same channel at one edge are both performed, so count is unchanged.
  - A full channel cannot enqueue that edge even if it is popped, because ready was computed from the registered count.
- Per-channel order: FIFO order is preserved. No ordering is guaranteed across channels.
- Tags are written exactly as supplied. Tag 0 is not special-cased here.
- Flush:
  - At an edge with flush=1, all FIFOs empty, pending_cnt<=0, wb_wr_en<=0, wb_grant<=0.
  - Enqueues in that cycle are dropped.
  - rr_ptr resets to 0.
- Reset mid-operation: buffered entries are lost and wb_wr_en drops immediately (async).
- pending_cnt = sum of per-channel counts, updated same edge as enqueue/pop/flush.
- Assertions (bench):
  - wb_grant is one-hot iff wb_wr_en is high, else zero.
  - pending_cnt <= NUM_FU*BUF_DEPTH.
  - No enqueue occurs while fu_ready[i]=0.

Test Plan:
1. Single result: after reset, ch1 offers tag 5, val 0xDEADBEEF for 1 cycle at edge N -> edge N+1: wb_wr_en=1, wb_phy_reg=5, wb_val=0xDEADBEEF, wb_grant=3'b010; edge N+2: wb_wr_en=0, pending_cnt=0.
2. Round-robin fairness: ch0/1/2 each enqueue 2 results (tags 10,11 / 20,21 / 30,31) same cycles -> write order 10,20,30,11,21,31 on consecutive cycles with no bubbles.
3. Backpressure: ch0 offers 3 results back-to-back while ch1, ch2 hold the arbiter busy -> fu_ready[0]=0 once ch0 count=2; third result accepted only after a ch0 pop; all three appear in order.
4. Full + pop same edge: ch2 full (count=2), fu_valid[2]=1 -> no enqueue at the pop edge; enqueue at the following edge; pending_cnt tracks exactly.
5. Flush: 5 entries buffered, flush=1 for one cycle with fu_valid[0]=1 -> pending_cnt=0, wb_wr_en=0 next cycle, the ch0 offer is dropped, rr_ptr=0 (next contest ch0 vs ch2 grants ch0).
6. Async reset mid-stream: assert reset between edges while wb_wr_en=1 -> wb_wr_en=0 and pending_cnt=0 immediately; fu_ready=3'b111 after release.
